muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit executing the RV32M-class ops next to the single-cycle ALU in EX.
//  Accepts one operation via valid/ready, computes in a radix-2 shift/add (mul) or restoring
//  (div) datapath, holds the result until consumed. Generalised over DATA_WIDTH; flushable.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width (>=4, even)
//  CNT_W       $clog2(DATA_WIDTH+1)  iteration counter width (derived, not overridden)
// PORTS
//  clk         in   1           clock, all state updates on rising edge
//  rst         in   1           asynchronous active-high reset
//  flush       in   1           synchronous abort of any in-flight op
//  in_valid    in   1           op/opr_a/opr_b valid
//  in_ready    out  1           unit can accept (state IDLE)
//  op          in   3           0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  opr_a       in   DATA_WIDTH  rs1 operand (multiplicand/dividend)
//  opr_b       in   DATA_WIDTH  rs2 operand (multiplier/divisor)
//  out_valid   out  1           opr_result valid
//  out_ready   in   1           consumer takes result
//  opr_result  out  DATA_WIDTH  result
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, opr_result=0, counter=0, internal regs=0.
//  FSM: IDLE -> CALC -> FIX -> DONE -> IDLE; special-case divide IDLE -> DONE directly.
//  IDLE: in_ready=1. On in_valid: latch op, operands; signed ops take magnitudes and record sign.
//   Signedness: MULH/DIV/REM both signed; MULHSU a signed, b unsigned; MULHU/DIVU/REMU unsigned.
//  CALC: exactly DATA_WIDTH cycles, one bit per cycle; 2*DATA_WIDTH product / quotient+remainder.
//  FIX: apply sign (negate product if signs differ; quotient sign = a^b, remainder sign = a);
//   select low half (MUL), high half (MULH*), quotient (DIV*), remainder (REM*).
//  DONE: out_valid=1, opr_result stable; leave to IDLE on out_ready. in_ready=0 in DONE.
//  Latency: handshake in cycle T -> out_valid first high in cycle T+DATA_WIDTH+2 (normal ops);
//   T+1 for special cases. Back-to-back: next accept no earlier than cycle after out_ready.
//  Special cases (decided in IDLE at accept, no CALC):
//   divisor==0: DIV/DIVU -> all ones; REM/REMU -> opr_a.
//   signed overflow (a=most-negative, b=-1) DIV -> opr_a; REM -> 0.
//  MUL result identical for signed/unsigned (low DATA_WIDTH bits of product).
//  flush: any state -> IDLE next cycle, out_valid=0, result discarded; flush has priority over
//   in_valid and out_ready in the same cycle (no accept while flush=1).
//  rst mid-op: immediate return to reset values, no partial result ever presented.
//  out_ready while out_valid=0 ignored. opr_result holds last value outside DONE (don't-care).
//  in_valid held with in_ready=0 is not consumed; operands may change until accepted.
// TESTING
//  MUL 7 x -3 (0x7,0xFFFFFFFD) -> 0xFFFFFFEB at T+34; MULH same -> 0xFFFFFFFF; MULHU -> 0x6.
//  MULHSU a=0x80000000,b=0xFFFFFFFF -> 0x80000000; MULH 0x80000000^2 -> 0x40000000.
//  DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
//  DIV x/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, REM -> 0, all at T+1.
//  out_ready held 0 for 10 cycles -> out_valid/opr_result stable, in_ready=0; then accepts next.
//  flush at CALC cycle 5 -> IDLE next cycle, no out_valid; rst mid-CALC -> all outputs reset.

Source files
------------

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//    Iterative RV32M-class multiply/divide unit that sits beside the EX-stage
//    ALU. It accepts one operation per valid/ready handshake. Multiplies use a
//    radix-2 shift/add datapath and divides use a restoring datapath, both
//    retiring one bit per cycle. The result is held until the consumer takes
//    it. The whole operation can be aborted with a synchronous flush.
//
// Ports
//    clk         in   1           rising-edge clock
//    rst         in   1           asynchronous active-high reset
//    flush       in   1           synchronous abort of any in-flight op
//    in_valid    in   1           op / opr_a / opr_b are valid
//    in_ready    out  1           unit can accept an op (IDLE)
//    op          in   3           0 MUL,1 MULH,2 MULHSU,3 MULHU,
//                                 4 DIV,5 DIVU,6 REM,7 REMU
//    opr_a       in   DATA_WIDTH  rs1 (multiplicand / dividend)
//    opr_b       in   DATA_WIDTH  rs2 (multiplier / divisor)
//    out_valid   out  1           opr_result is valid
//    out_ready   in   1           consumer takes the result
//    opr_result  out  DATA_WIDTH  result
// ---------------------------------------------------------------------------
module muldiv_unit #(
   parameter  int DATA_WIDTH = 32,
   localparam int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] opr_a,
   input  logic [DATA_WIDTH-1:0] opr_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] opr_result
);

   localparam int W = DATA_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Two's-complement negation, single width
   function automatic logic [W-1:0] f_neg(input logic [W-1:0] x);
      f_neg = (~x) + W'(1);
   endfunction

   // Two's-complement negation, double width (full product)
   function automatic logic [2*W-1:0] f_neg2(input logic [2*W-1:0] x);
      f_neg2 = (~x) + (2*W)'(1);
   endfunction

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [W-1:0]     hi_q, hi_d;        // product high half / partial remainder
   logic [W-1:0]     lo_q, lo_d;        // product low half (multiplier) / quotient (dividend)
   logic [W-1:0]     mcand_q, mcand_d;  // multiplicand magnitude / divisor magnitude
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             a_neg_q, a_neg_d;
   logic             b_neg_q, b_neg_d;
   logic [W-1:0]     res_q, res_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q, in_ready_d;

   // ---------------- accept-time decode ----------------
   logic           is_div_s;
   logic           a_signed_s, b_signed_s;
   logic           a_neg_in_s, b_neg_in_s;
   logic [W-1:0]   a_mag_s, b_mag_s;
   logic           div_zero_s, div_ovf_s;
   logic [W-1:0]   special_res_s;

   // Operand signedness per opcode
   always_comb begin
      a_signed_s = 1'b0;
      b_signed_s = 1'b0;
      case (op)
         3'd1, 3'd4, 3'd6: begin
            a_signed_s = 1'b1;
            b_signed_s = 1'b1;
         end
         3'd2: begin
            a_signed_s = 1'b1;
            b_signed_s = 1'b0;
         end
         default: begin
            a_signed_s = 1'b0;
            b_signed_s = 1'b0;
         end
      endcase
   end

   assign is_div_s   = op[2];
   assign a_neg_in_s = a_signed_s & opr_a[W-1];
   assign b_neg_in_s = b_signed_s & opr_b[W-1];
   // The most-negative value maps to 2^(W-1), which still fits unsigned in W bits
   assign a_mag_s    = a_neg_in_s ? f_neg(opr_a) : opr_a;
   assign b_mag_s    = b_neg_in_s ? f_neg(opr_b) : opr_b;
   assign div_zero_s = (opr_b == {W{1'b0}});
   assign div_ovf_s  = (op == 3'd4 || op == 3'd6) &&
                       (opr_a == {1'b1, {(W-1){1'b0}}}) &&
                       (opr_b == {W{1'b1}});

   // Results of the divide cases that bypass the iterative datapath; op[1] selects REM*
   always_comb begin
      special_res_s = {W{1'b0}};
      if (div_zero_s) begin
         special_res_s = op[1] ? opr_a : {W{1'b1}};
      end else begin
         special_res_s = op[1] ? {W{1'b0}} : opr_a;
      end
   end

   // ---------------- iteration datapath ----------------
   logic [W:0]     mul_sum_s;
   logic [W:0]     div_shift_s;
   logic [W+1:0]   div_diff_s;
   logic [2*W-1:0] prod_s, prod_signed_s;

   // Shift/add: add the multiplicand when the current multiplier bit is set
   assign mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
   // Restoring divide: bring the next dividend bit into the partial remainder
   assign div_shift_s = {hi_q, lo_q[W-1]};
   assign div_diff_s  = {1'b0, div_shift_s} - {2'b00, mcand_q};

   assign prod_s        = {hi_q, lo_q};
   assign prod_signed_s = (a_neg_q ^ b_neg_q) ? f_neg2(prod_s) : prod_s;

   // Next-state, datapath and output-register decode
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      mcand_d     = mcand_q;
      cnt_d       = cnt_q;
      a_neg_d     = a_neg_q;
      b_neg_d     = b_neg_q;
      res_d       = res_q;

      if (flush) begin
         // Abort wins over accept and consume; datapath contents become stale
         state_d = S_IDLE;
         cnt_d   = {CNT_W{1'b0}};
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  op_d    = op;
                  a_neg_d = a_neg_in_s;
                  b_neg_d = b_neg_in_s;
                  if (is_div_s && (div_zero_s || div_ovf_s)) begin
                     res_d   = special_res_s;
                     state_d = S_DONE;
                  end else begin
                     hi_d    = {W{1'b0}};
                     lo_d    = is_div_s ? a_mag_s : b_mag_s;
                     mcand_d = is_div_s ? b_mag_s : a_mag_s;
                     cnt_d   = CNT_W'(W);
                     state_d = S_CALC;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end

            S_CALC: begin
               if (op_q[2]) begin
                  // Non-negative difference means the divisor fits: keep it, quotient bit 1
                  if (!div_diff_s[W+1]) begin
                     hi_d = div_diff_s[W-1:0];
                     lo_d = {lo_q[W-2:0], 1'b1};
                  end else begin
                     hi_d = div_shift_s[W-1:0];
                     lo_d = {lo_q[W-2:0], 1'b0};
                  end
               end else begin
                  hi_d = mul_sum_s[W:1];
                  lo_d = {mul_sum_s[0], lo_q[W-1:1]};
               end
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = S_FIX;
               end else begin
                  state_d = S_CALC;
               end
            end

            S_FIX: begin
               if (op_q[2]) begin
                  if (op_q[1]) begin
                     // Remainder takes the dividend's sign
                     res_d = a_neg_q ? f_neg(hi_q) : hi_q;
                  end else begin
                     res_d = (a_neg_q ^ b_neg_q) ? f_neg(lo_q) : lo_q;
                  end
               end else begin
                  if (op_q[1:0] == 2'd0) begin
                     res_d = prod_signed_s[W-1:0];
                  end else begin
                     res_d = prod_signed_s[2*W-1:W];
                  end
               end
               state_d = S_DONE;
            end

            S_DONE: begin
               if (out_ready) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DONE;
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      out_valid_d = (state_d == S_DONE);
      in_ready_d  = (state_d == S_IDLE);
   end

   // State, datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= 3'd0;
         hi_q        <= {W{1'b0}};
         lo_q        <= {W{1'b0}};
         mcand_q     <= {W{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         a_neg_q     <= 1'b0;
         b_neg_q     <= 1'b0;
         res_q       <= {W{1'b0}};
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         mcand_q     <= mcand_d;
         cnt_q       <= cnt_d;
         a_neg_q     <= a_neg_d;
         b_neg_q     <= b_neg_d;
         res_q       <= res_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign opr_result = res_q;

endmodule
